// File: rtl/uart_pkg.sv
// Shared definitions for the MIPS_UART receive path: FSM state encoding,
// oversampling constants and the even-parity helper.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing when defined).
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Sample-count values at which the FSM looks at the line.
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  // Even parity: XOR of all data bits; the wire parity bit must equal this.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every BAUD_DIV clocks.
// The synchronous clr input holds the count at 0 so tick phase can be
// re-aligned to an external event (the receiver's start edge).
module uart_baud_tick #(
  parameter int BAUD_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  // Next count: held at zero while cleared, otherwise wraps at BAUD_DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 16'd0;
    end else if (cnt_q == LAST) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver with a valid/ready output byte register.
// Frames 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a live
// parity_err output. rst is asynchronous and active low.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  logic sync1_q, sync2_q, rx_s, tick_s;
  state_e state_q, state_d;
  logic [3:0] samp_q, samp_d;
  logic [2:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic deliver_s, ferr_s, perr_s, par_bad_s;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d, ferr_q, perr_q, ovr_q, ovr_d;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  assign par_bad_s = par_bad_q;
`else
  assign par_bad_s = 1'b0;
`endif

  // Two-flop synchronizer on the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_IDLE),
    .tick (tick_s)
  );

  // Frame FSM: start validation, data shift, optional parity, stop check.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    deliver_s = 1'b0;
    ferr_s    = 1'b0;
    perr_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    if (tick_s) begin
      samp_d = samp_q + 4'd1;
    end else begin
      samp_d = samp_q;
    end
    case (state_q)
      ST_IDLE: begin
        samp_d = 4'd0;
        if (!rx_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && samp_q == MID_SAMPLE) begin
          if (!rx_s) begin
            state_d = ST_DATA;
            samp_d  = 4'd0;
            idx_d   = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && samp_q == LAST_SAMPLE) begin
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_s && samp_q == LAST_SAMPLE) begin
          par_bad_d = rx_s ^ even_parity(shift_q);
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s && samp_q == LAST_SAMPLE) begin
          if (!rx_s) begin
            ferr_s  = 1'b1;
            state_d = ST_BREAK;
          end else if (par_bad_s) begin
            perr_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            deliver_s = 1'b1;
            state_d   = ST_IDLE;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_BREAK: begin
        // A held-low line stays here so it reports only one frame error.
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output byte register: load when empty or being consumed, else overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (deliver_s) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State, counters, output register and single-cycle flag pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      samp_q  <= 4'd0;
      idx_q   <= 3'd0;
      shift_q <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_s;
      perr_q  <= perr_s;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
